// File: rtl/eth_test_pattern_gen.sv
// -----------------------------------------------------------------------------
// eth_test_pattern_gen
//
// Test-frame source for the MAC TX path. Each frame is one Ethernet header
// handshake followed by an AXI-stream payload: an 8-byte prefix (type flag,
// timestamp, three zero bytes, 16-bit sequence index) and a body of
// cfg_payload_len pattern bytes. Supports four pattern modes, an inter-frame
// gap, burst or continuous frame counts and a completed-frame counter.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   enable                           run request (level)
//   cfg_mode                         0 counter, 1 PRBS7, 2 fixed byte, 3 DPA
//   cfg_payload_len                  body bytes per frame (0 behaves as 1)
//   cfg_frame_count                  frames per burst, 0 = continuous
//   cfg_gap                          idle cycles after each tlast
//   cfg_fixed_byte                   body byte for mode 2
//   packet_index_base                sequence index of a burst's first frame
//   timestamp                        captured into prefix bytes 1..2
//   src_mac, dst_mac                 header pass-through fields
//   m_eth_hdr_*                      header valid/ready and fields
//   m_eth_payload_axis_*             payload stream (tuser tied low)
//   is_data, is_timestamp0/1         byte-position flags aligned with tdata
//   frames_sent                      frames completed since reset
//   burst_done                       burst of cfg_frame_count frames finished
//   busy                             generator is not idle
// -----------------------------------------------------------------------------
module eth_test_pattern_gen #(
    parameter int          DATA_WIDTH = 8,   // only 8 is legal
    parameter int          LEN_WIDTH  = 11,
    parameter logic [15:0] ETH_TYPE   = 16'h88B5,
    parameter logic [7:0]  TYPE_FLAG  = 8'h07,
    parameter logic [19:0] DPA_SEED   = 20'h003FF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [1:0]            cfg_mode,
    input  logic [LEN_WIDTH-1:0]  cfg_payload_len,
    input  logic [15:0]           cfg_frame_count,
    input  logic [31:0]           cfg_gap,
    input  logic [7:0]            cfg_fixed_byte,
    input  logic [15:0]           packet_index_base,
    input  logic [15:0]           timestamp,
    input  logic [47:0]           src_mac,
    input  logic [47:0]           dst_mac,
    output logic                  m_eth_hdr_valid,
    input  logic                  m_eth_hdr_ready,
    output logic [47:0]           m_eth_dest_mac,
    output logic [47:0]           m_eth_src_mac,
    output logic [15:0]           m_eth_type,
    output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
    output logic                  m_eth_payload_axis_tvalid,
    input  logic                  m_eth_payload_axis_tready,
    output logic                  m_eth_payload_axis_tlast,
    output logic                  m_eth_payload_axis_tuser,
    output logic                  is_data,
    output logic                  is_timestamp0,
    output logic                  is_timestamp1,
    output logic [31:0]           frames_sent,
    output logic                  burst_done,
    output logic                  busy
);

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PREFIX, S_DATA, S_GAP} state_e;
    typedef enum logic [1:0] {MODE_COUNTER, MODE_PRBS7, MODE_FIXED, MODE_DPA} mode_e;

    state_e               state_q, state_d;
    mode_e                mode_q, mode_d;
    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;          // byte index within prefix / body
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [7:0]           fixed_q, fixed_d;
    logic [31:0]          gap_q, gap_d;
    logic [31:0]          gap_cnt_q, gap_cnt_d;
    logic [15:0]          seq_q, seq_d;
    logic [15:0]          burst_cnt_q, burst_cnt_d;
    logic                 burst_done_q, burst_done_d;
    logic [31:0]          frames_q, frames_d;
    logic [15:0]          ts_q, ts_d;
    logic [7:0]           ctr_q, ctr_d;
    logic [6:0]           prbs_q, prbs_d;
    logic [19:0]          dpa_q, dpa_d;

    logic                 payload_fire;
    logic                 last_byte;
    logic                 load_cfg;
    logic [7:0]           prbs_byte;
    logic [6:0]           prbs_next;
    logic [7:0]           pat_byte;
    logic [7:0]           prefix_byte;
    logic [7:0]           tdata_c;

    assign payload_fire = m_eth_payload_axis_tvalid && m_eth_payload_axis_tready;
    assign last_byte    = (state_q == S_DATA) && (cnt_q == len_q - LEN_WIDTH'(1));

    // Eight PRBS7 steps per byte; first generated bit lands in the MSB.
    always_comb begin : prbs_step
        logic [6:0] s;
        logic       fb;
        s         = prbs_q;
        prbs_byte = '0;
        for (int i = 7; i >= 0; i--) begin
            fb           = s[6] ^ s[5];
            prbs_byte[i] = fb;
            s            = {s[5:0], fb};
        end
        prbs_next = s;
    end

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d      = state_q;
        mode_d       = mode_q;
        cnt_d        = cnt_q;
        len_d        = len_q;
        fixed_d      = fixed_q;
        gap_d        = gap_q;
        gap_cnt_d    = gap_cnt_q;
        seq_d        = seq_q;
        burst_cnt_d  = burst_cnt_q;
        burst_done_d = burst_done_q;
        frames_d     = frames_q;
        ts_d         = ts_q;
        ctr_d        = ctr_q;
        prbs_d       = prbs_q;
        dpa_d        = dpa_q;
        load_cfg     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!enable) begin
                    burst_cnt_d  = '0;
                    burst_done_d = 1'b0;
                end else if (!burst_done_q) begin
                    load_cfg = 1'b1;
                    if (burst_cnt_q == '0) seq_d = packet_index_base;
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                if (m_eth_hdr_ready) begin
                    ts_d    = timestamp;     // held for the frame so stalls cannot disturb tdata
                    cnt_d   = '0;
                    state_d = S_PREFIX;
                end
            end
            S_PREFIX: begin
                if (m_eth_payload_axis_tready) begin
                    if (cnt_q == LEN_WIDTH'(7)) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end else begin
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            S_DATA: begin
                if (m_eth_payload_axis_tready) begin
                    if (last_byte) begin
                        frames_d    = frames_q + 32'd1;
                        seq_d       = seq_q + 16'd1;
                        burst_cnt_d = burst_cnt_q + 16'd1;
                        cnt_d       = '0;
                        if (cfg_frame_count != '0 && burst_cnt_d == cfg_frame_count) begin
                            burst_done_d = 1'b1;
                            state_d      = S_IDLE;
                        end else if (!enable) begin
                            state_d = S_IDLE;
                        end else if (gap_q == '0) begin
                            load_cfg = 1'b1;
                            state_d  = S_HDR;
                        end else begin
                            gap_cnt_d = gap_q;
                            state_d   = S_GAP;
                        end
                    end else begin
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            S_GAP: begin
                if (gap_cnt_q <= 32'd1) begin
                    gap_cnt_d = '0;
                    load_cfg  = 1'b1;
                    state_d   = S_HDR;
                end else begin
                    gap_cnt_d = gap_cnt_q - 32'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Pattern generators only move on an accepted byte.
        if (payload_fire) begin
            if (mode_q == MODE_DPA) dpa_d = {dpa_q[17:0], dpa_q[19:18]};
            if (state_q == S_DATA) begin
                if (mode_q == MODE_COUNTER) ctr_d  = ctr_q + 8'd1;
                if (mode_q == MODE_PRBS7)   prbs_d = prbs_next;
            end
        end

        // Configuration is sampled only at frame starts.
        if (load_cfg) begin
            mode_d  = mode_e'(cfg_mode);
            len_d   = (cfg_payload_len == '0) ? LEN_WIDTH'(1) : cfg_payload_len;
            fixed_d = cfg_fixed_byte;
            gap_d   = cfg_gap;
        end
    end

    // NOTE: state registers use non-blocking assignments; reset is asynchronous and active-low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            mode_q       <= MODE_COUNTER;
            cnt_q        <= '0;
            len_q        <= '0;
            fixed_q      <= '0;
            gap_q        <= '0;
            gap_cnt_q    <= '0;
            seq_q        <= '0;
            burst_cnt_q  <= '0;
            burst_done_q <= 1'b0;
            frames_q     <= '0;
            ts_q         <= '0;
            ctr_q        <= '0;
            prbs_q       <= 7'h7F;
            dpa_q        <= DPA_SEED;
        end else begin
            state_q      <= state_d;
            mode_q       <= mode_d;
            cnt_q        <= cnt_d;
            len_q        <= len_d;
            fixed_q      <= fixed_d;
            gap_q        <= gap_d;
            gap_cnt_q    <= gap_cnt_d;
            seq_q        <= seq_d;
            burst_cnt_q  <= burst_cnt_d;
            burst_done_q <= burst_done_d;
            frames_q     <= frames_d;
            ts_q         <= ts_d;
            ctr_q        <= ctr_d;
            prbs_q       <= prbs_d;
            dpa_q        <= dpa_d;
        end
    end

    // Payload byte selection; DPA mode replaces the prefix bytes as well.
    always_comb begin
        unique case (mode_q)
            MODE_COUNTER: pat_byte = ctr_q;
            MODE_PRBS7:   pat_byte = prbs_byte;
            MODE_FIXED:   pat_byte = fixed_q;
            default:      pat_byte = {{4{dpa_q[19]}}, {4{dpa_q[18]}}};
        endcase
        unique case (cnt_q[2:0])
            3'd0:    prefix_byte = TYPE_FLAG;
            3'd1:    prefix_byte = ts_q[7:0];
            3'd2:    prefix_byte = ts_q[15:8];
            3'd6:    prefix_byte = seq_q[7:0];
            3'd7:    prefix_byte = seq_q[15:8];
            default: prefix_byte = 8'h00;
        endcase
        tdata_c = 8'h00;
        if (state_q == S_PREFIX)    tdata_c = (mode_q == MODE_DPA) ? pat_byte : prefix_byte;
        else if (state_q == S_DATA) tdata_c = pat_byte;
    end

    assign m_eth_hdr_valid           = (state_q == S_HDR);
    assign m_eth_dest_mac            = dst_mac;
    assign m_eth_src_mac             = src_mac;
    assign m_eth_type                = ETH_TYPE;
    assign m_eth_payload_axis_tdata  = tdata_c;
    assign m_eth_payload_axis_tvalid = (state_q == S_PREFIX) || (state_q == S_DATA);
    assign m_eth_payload_axis_tlast  = last_byte;
    assign m_eth_payload_axis_tuser  = 1'b0;
    assign is_data                   = (state_q == S_DATA);
    assign is_timestamp0             = (state_q == S_PREFIX) && (cnt_q == LEN_WIDTH'(1));
    assign is_timestamp1             = (state_q == S_PREFIX) && (cnt_q == LEN_WIDTH'(2));
    assign frames_sent               = frames_q;
    assign burst_done                = burst_done_q;
    assign busy                      = (state_q != S_IDLE);

endmodule
